// File: rtl/adi_wb_bridge.sv
// EPP byte-register to Wishbone bridge: stages address/data in host-visible registers
// and runs one arbitrated Wishbone single access per trigger.
module adi_wb_bridge #(
  parameter int WB_AW   = 32,
  parameter int WB_DW   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                 CLK,
  input  logic                 RST_ASYNC,
  input  logic                 EN,
  input  logic                 REGS_WRITE_REQ_IN,
  input  logic                 REGS_READ_REQ_IN,
  input  logic                 REGS_ADDR_SEL_IN,
  input  logic                 REGS_DATA_SEL_IN,
  input  logic [7:0]           REGS_WRITE_DATA_IN,
  output logic [7:0]           REGS_READ_DATA_OUT,
  output logic                 REGS_WRITE_ACK_OUT,
  output logic                 REGS_READ_ACK_OUT,
  output logic                 WB_ARB_REQ_OUT,
  input  logic                 WB_ARB_GNT_IN,
  output logic                 WB_CYC_OUT,
  output logic                 WB_STB_OUT,
  output logic                 WB_WE_OUT,
  output logic [WB_AW-1:0]     WB_ADR_OUT,
  output logic [WB_DW/8-1:0]   WB_SEL_OUT,
  output logic [WB_DW-1:0]     WB_WR_DAT_OUT,
  input  logic                 WB_STALL_IN,
  input  logic                 WB_ACK_IN,
  input  logic                 WB_ERR_IN,
  input  logic [WB_DW-1:0]     WB_RD_DAT_IN
);

  localparam int NB = WB_DW / 8;
  localparam int AB = (WB_AW + 7) / 8;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_STB, S_WAIT, S_REL} state_t;

  state_t             r_state;
  logic [7:0]         r_idx;
  logic [WB_AW-1:0]   r_adr;
  logic [WB_DW-1:0]   r_dat;
  logic               r_auto_inc, r_auto_trig, r_err, r_tmo;
  logic [CW-1:0]      r_tcnt;
  logic               r_pv, r_pwr, r_pasel, r_pdsel;
  logic [7:0]         r_pdata, r_rdata;
  logic               r_wack, r_rack, r_req, r_cyc, r_stb, r_we;
  logic [WB_AW-1:0]   r_badr;
  logic [NB-1:0]      r_sel;
  logic [WB_DW-1:0]   r_wdat;

  logic               w_new, w_av, w_wr, w_asel, w_dsel, w_busy, w_stat, w_go;
  logic               w_adr_ok, w_is_dat, w_is_ctrl, w_trig_wr, w_trig_rd;
  logic [7:0]         w_wdata, w_rbyte;
  logic [31:0]        w_adr32, w_dat32, w_adr_nx, w_dat_nx;
  logic [4:0]         w_bofs;

  assign REGS_READ_DATA_OUT = r_rdata;
  assign REGS_WRITE_ACK_OUT = r_wack;
  assign REGS_READ_ACK_OUT  = r_rack;
  assign WB_ARB_REQ_OUT     = r_req;
  assign WB_CYC_OUT         = r_cyc;
  assign WB_STB_OUT         = r_stb;
  assign WB_WE_OUT          = r_we;
  assign WB_ADR_OUT         = r_badr;
  assign WB_SEL_OUT         = r_sel;
  assign WB_WR_DAT_OUT      = r_wdat;

  // A request is served straight from the port unless one is already parked.
  assign w_new   = (REGS_WRITE_REQ_IN | REGS_READ_REQ_IN) & ~r_pv;
  assign w_av    = r_pv | w_new;
  assign w_wr    = r_pv ? r_pwr   : REGS_WRITE_REQ_IN;
  assign w_asel  = r_pv ? r_pasel : REGS_ADDR_SEL_IN;
  assign w_dsel  = (r_pv ? r_pdsel : REGS_DATA_SEL_IN) & ~w_asel;
  assign w_wdata = r_pv ? r_pdata : REGS_WRITE_DATA_IN;

  assign w_busy    = (r_state != S_IDLE);
  assign w_stat    = w_dsel & (r_idx == 8'h09);
  assign w_go      = w_av & EN & ~(w_busy & ~w_stat);
  assign w_adr_ok  = w_dsel & (r_idx < 8'(AB));
  assign w_is_dat  = w_dsel & (r_idx >= 8'h04) & (r_idx < 8'(4 + NB));
  assign w_is_ctrl = w_dsel & (r_idx == 8'h08);
  assign w_bofs    = {r_idx[1:0], 3'b000};
  assign w_adr32   = 32'(r_adr);
  assign w_dat32   = 32'(r_dat);

  assign w_trig_wr = w_go & w_wr & ((w_is_ctrl & w_wdata[1]) |
                     (w_dsel & r_auto_trig & (r_idx == 8'(3 + NB))));
  assign w_trig_rd = (w_go & w_wr & w_is_ctrl & w_wdata[0] & ~w_wdata[1]) |
                     (w_go & ~w_wr & w_dsel & r_auto_trig & (r_idx == 8'h04));

  always_comb begin
    w_adr_nx = w_adr32;
    w_adr_nx[w_bofs +: 8] = w_wdata;
    w_dat_nx = w_dat32;
    w_dat_nx[w_bofs +: 8] = w_wdata;
    w_rbyte = 8'h00;
    if (w_asel)         w_rbyte = r_idx;
    else if (w_adr_ok)  w_rbyte = w_adr32[w_bofs +: 8];
    else if (w_is_dat)  w_rbyte = w_dat32[w_bofs +: 8];
    else if (w_is_ctrl) w_rbyte = {4'b0000, r_auto_trig, r_auto_inc, 2'b00};
    else if (w_stat)    w_rbyte = {5'b00000, r_tmo, r_err, w_busy};
  end

  always_ff @(posedge CLK or negedge RST_ASYNC) begin
    if (!RST_ASYNC) begin
      r_state <= S_IDLE;  r_idx <= '0;  r_adr <= '0;  r_dat <= '0;
      r_auto_inc <= 1'b0; r_auto_trig <= 1'b0; r_err <= 1'b0; r_tmo <= 1'b0;
      r_tcnt <= '0;       r_pv <= 1'b0; r_pwr <= 1'b0; r_pasel <= 1'b0;
      r_pdsel <= 1'b0;    r_pdata <= '0; r_rdata <= '0; r_wack <= 1'b0;
      r_rack <= 1'b0;     r_req <= 1'b0; r_cyc <= 1'b0; r_stb <= 1'b0;
      r_we <= 1'b0;       r_badr <= '0; r_sel <= '0;  r_wdat <= '0;
    end else begin
      r_wack <= 1'b0;
      r_rack <= 1'b0;
      if (w_go) begin
        r_pv <= 1'b0;
        if (w_wr) begin
          r_wack <= 1'b1;
          if (w_asel)         r_idx <= w_wdata;
          else if (w_adr_ok)  r_adr <= w_adr_nx[WB_AW-1:0];
          else if (w_is_dat)  r_dat <= w_dat_nx[WB_DW-1:0];
          else if (w_is_ctrl) {r_auto_trig, r_auto_inc} <= w_wdata[3:2];
        end else begin
          r_rack  <= 1'b1;
          r_rdata <= w_rbyte;
          if (w_stat) begin
            r_err <= 1'b0;
            r_tmo <= 1'b0;
          end
        end
      end else if (w_new) begin
        r_pv    <= 1'b1;
        r_pwr   <= REGS_WRITE_REQ_IN;
        r_pasel <= REGS_ADDR_SEL_IN;
        r_pdsel <= REGS_DATA_SEL_IN;
        r_pdata <= REGS_WRITE_DATA_IN;
      end

      // Bus FSM; status set here after the STAT-read clear so a new flag is never lost.
      if (EN) begin
        case (r_state)
          S_IDLE: if (w_trig_wr | w_trig_rd) begin
            r_state <= S_REQ;
            r_req   <= 1'b1;
            r_we    <= w_trig_wr;
          end
          S_REQ: if (WB_ARB_GNT_IN) begin
            r_state <= S_STB;
            r_cyc   <= 1'b1;
            r_stb   <= 1'b1;
            r_badr  <= r_adr & ~WB_AW'(NB - 1);
            r_sel   <= '1;
            r_wdat  <= r_dat;
          end
          S_STB: if (!WB_STALL_IN) begin
            r_state <= S_WAIT;
            r_stb   <= 1'b0;
            r_tcnt  <= '0;
          end
          S_WAIT: begin
            r_tcnt <= r_tcnt + 1'b1;
            if (WB_ACK_IN) begin
              if (!r_we)      r_dat <= WB_RD_DAT_IN;
              if (r_auto_inc) r_adr <= r_adr + WB_AW'(NB);
              r_state <= S_REL;
              r_cyc   <= 1'b0;
              r_req   <= 1'b0;
            end else if (WB_ERR_IN) begin
              r_err   <= 1'b1;
              r_state <= S_REL;
              r_cyc   <= 1'b0;
              r_req   <= 1'b0;
            end else if ((TIMEOUT != 0) && (r_tcnt == CW'(TIMEOUT))) begin
              r_tmo   <= 1'b1;
              r_state <= S_REL;
              r_cyc   <= 1'b0;
              r_req   <= 1'b0;
            end
          end
          S_REL: if (!WB_ARB_GNT_IN) r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adi_wb_bridge.sv
// Directed bench for adi_wb_bridge: a 32-bit instance (TIMEOUT=16) and a 16-bit instance
// share one host port and one Wishbone slave model, selected by use16.
module tb_adi_wb_bridge;

  logic        clk = 1'b0, rst_n = 1'b0, en = 1'b1, use16 = 1'b0;
  logic        h_wr = 1'b0, h_rd = 1'b0, h_asel = 1'b0, h_dsel = 1'b0;
  logic [7:0]  h_wdata = 8'h00;
  logic        gnt = 1'b0, stall = 1'b0, ack = 1'b0, err = 1'b0;
  logic [31:0] rd_dat = 32'h0;
  int          checks = 0, failures = 0;

  logic [7:0]  a_rdata, b_rdata;
  logic        a_wack, a_rack, a_req, a_cyc, a_stb, a_we;
  logic        b_wack, b_rack, b_req, b_cyc, b_stb, b_we;
  logic [31:0] a_adr, b_adr, a_wdat;
  logic [15:0] b_wdat;
  logic [3:0]  a_sel;
  logic [1:0]  b_sel;

  adi_wb_bridge #(.WB_AW(32), .WB_DW(32), .TIMEOUT(16)) dut32 (
    .CLK(clk), .RST_ASYNC(rst_n), .EN(en),
    .REGS_WRITE_REQ_IN(h_wr & ~use16), .REGS_READ_REQ_IN(h_rd & ~use16),
    .REGS_ADDR_SEL_IN(h_asel), .REGS_DATA_SEL_IN(h_dsel), .REGS_WRITE_DATA_IN(h_wdata),
    .REGS_READ_DATA_OUT(a_rdata), .REGS_WRITE_ACK_OUT(a_wack), .REGS_READ_ACK_OUT(a_rack),
    .WB_ARB_REQ_OUT(a_req), .WB_ARB_GNT_IN(gnt), .WB_CYC_OUT(a_cyc), .WB_STB_OUT(a_stb),
    .WB_WE_OUT(a_we), .WB_ADR_OUT(a_adr), .WB_SEL_OUT(a_sel), .WB_WR_DAT_OUT(a_wdat),
    .WB_STALL_IN(stall), .WB_ACK_IN(ack), .WB_ERR_IN(err), .WB_RD_DAT_IN(rd_dat));

  adi_wb_bridge #(.WB_AW(32), .WB_DW(16), .TIMEOUT(255)) dut16 (
    .CLK(clk), .RST_ASYNC(rst_n), .EN(en),
    .REGS_WRITE_REQ_IN(h_wr & use16), .REGS_READ_REQ_IN(h_rd & use16),
    .REGS_ADDR_SEL_IN(h_asel), .REGS_DATA_SEL_IN(h_dsel), .REGS_WRITE_DATA_IN(h_wdata),
    .REGS_READ_DATA_OUT(b_rdata), .REGS_WRITE_ACK_OUT(b_wack), .REGS_READ_ACK_OUT(b_rack),
    .WB_ARB_REQ_OUT(b_req), .WB_ARB_GNT_IN(gnt), .WB_CYC_OUT(b_cyc), .WB_STB_OUT(b_stb),
    .WB_WE_OUT(b_we), .WB_ADR_OUT(b_adr), .WB_SEL_OUT(b_sel), .WB_WR_DAT_OUT(b_wdat),
    .WB_STALL_IN(stall), .WB_ACK_IN(ack), .WB_ERR_IN(err), .WB_RD_DAT_IN(rd_dat[15:0]));

  wire [7:0]  m_rdata = use16 ? b_rdata : a_rdata;
  wire        m_wack  = use16 ? b_wack  : a_wack;
  wire        m_rack  = use16 ? b_rack  : a_rack;
  wire        m_req   = use16 ? b_req   : a_req;
  wire        m_cyc   = use16 ? b_cyc   : a_cyc;
  wire        m_stb   = use16 ? b_stb   : a_stb;
  wire        m_we    = use16 ? b_we    : a_we;
  wire [31:0] m_adr   = use16 ? b_adr   : a_adr;
  wire [3:0]  m_sel   = use16 ? {2'b00, b_sel} : a_sel;
  wire [31:0] m_wdat  = use16 ? {16'h0, b_wdat} : a_wdat;

  always #5 clk = ~clk;

  // Slave model: GNT registered from REQ, configurable stall, ACK / no-reply / ERR.
  int          ack_mode = 0, stall_cfg = 0;
  int          stall_cnt = 0, cyc_cnt = 0, log_n = 0, acc_cyc = 0, drop_cyc = 0;
  logic        prev_cyc = 1'b0;
  logic [31:0] log_adr [16];
  logic [31:0] log_dat [16];
  logic [3:0]  log_sel [16];
  logic        log_we  [16];

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin : slave
    logic st;
    st = m_stb && (stall_cnt < stall_cfg);
    stall     <= st;
    stall_cnt <= m_stb ? stall_cnt + 1 : 0;
    gnt       <= m_req;
    ack       <= (ack_mode == 0) && m_cyc && !m_stb;
    err       <= (ack_mode == 2) && m_cyc && !m_stb;
    if (m_stb && !st && log_n < 16) begin
      log_adr[log_n] <= m_adr;
      log_dat[log_n] <= m_wdat;
      log_sel[log_n] <= m_sel;
      log_we[log_n]  <= m_we;
      acc_cyc        <= cyc_cnt;
      log_n          <= log_n + 1;
    end
    if (prev_cyc && !m_cyc) drop_cyc <= cyc_cnt;
    prev_cyc <= m_cyc;
  end

  task automatic access(input logic wr, input logic asel, input logic [7:0] d,
                        output logic [7:0] q, output int waited);
    @(negedge clk);
    h_wr = wr; h_rd = ~wr; h_asel = asel; h_dsel = ~asel; h_wdata = d;
    @(negedge clk);
    h_wr = 1'b0; h_rd = 1'b0;
    waited = 0;
    while (!(m_wack || m_rack) && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    q = m_rdata;
    if (waited >= 300) begin
      checks++; failures++;
      $display("FAIL reg_ack_wait got=no_ack exp=ack idx_or_data=%h", d);
    end
  endtask

  task automatic wr_reg(input logic [7:0] i, input logic [7:0] d);
    logic [7:0] q; int w;
    access(1'b1, 1'b1, i, q, w);
    access(1'b1, 1'b0, d, q, w);
  endtask

  task automatic rd_reg(input logic [7:0] i, output logic [7:0] q);
    logic [7:0] d; int w;
    access(1'b1, 1'b1, i, d, w);
    access(1'b0, 1'b0, 8'h00, q, w);
  endtask

  task automatic wait_idle();
    int n = 0;
    repeat (2) @(negedge clk);
    while ((m_req || gnt || m_cyc) && n < 300) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    if (n >= 300) begin
      checks++; failures++;
      $display("FAIL idle_wait got=busy exp=idle");
    end
  endtask

  task automatic test_reset();
    logic [7:0] q; int w;
    repeat (3) @(negedge clk);
    checks++;
    if ({m_req, m_cyc, m_stb, m_we, a_adr, a_sel, a_wdat, a_wack, a_rack, a_rdata} !== '0) begin
      failures++; $display("FAIL reset_outputs got=%b%b%b%b adr=%h exp=0", m_req, m_cyc, m_stb, m_we, a_adr);
    end
    rst_n = 1'b1;
    access(1'b0, 1'b1, 8'h00, q, w);
    checks++;
    if (q !== 8'h00 || w !== 0) begin
      failures++; $display("FAIL reset_idx got=%h lat=%0d exp=00 lat=0", q, w);
    end
    rd_reg(8'h09, q);
    checks++; if (q !== 8'h00) begin failures++; $display("FAIL reset_stat got=%h exp=00", q); end
  endtask

  task automatic test_write();
    logic [7:0] q; int base = log_n;
    wr_reg(8'h00, 8'h00); wr_reg(8'h01, 8'h10); wr_reg(8'h02, 8'h00); wr_reg(8'h03, 8'h00);
    wr_reg(8'h04, 8'hEF); wr_reg(8'h05, 8'hBE); wr_reg(8'h06, 8'hAD); wr_reg(8'h07, 8'hDE);
    wr_reg(8'h08, 8'h02);
    checks++; if (m_req !== 1'b1) begin failures++; $display("FAIL go_wr_req_latency got=%b exp=1", m_req); end
    wait_idle();
    checks++;
    if (log_n !== base + 1 || log_adr[base] !== 32'h1000 || log_we[base] !== 1'b1 ||
        log_sel[base] !== 4'hF || log_dat[base] !== 32'hDEADBEEF) begin
      failures++; $display("FAIL single_write got=n%0d adr=%h we=%b sel=%h dat=%h exp=adr 1000 we 1 sel f dat deadbeef",
                           log_n - base, log_adr[base], log_we[base], log_sel[base], log_dat[base]);
    end
    rd_reg(8'h09, q);
    checks++; if (q !== 8'h00) begin failures++; $display("FAIL write_stat got=%h exp=00", q); end
    rd_reg(8'h08, q);
    checks++; if (q !== 8'h00) begin failures++; $display("FAIL go_selfclear got=%h exp=00", q); end
  endtask

  task automatic test_auto_inc();
    logic [7:0] q; int base = log_n;
    wr_reg(8'h08, 8'h0C);
    for (int k = 0; k < 4; k++)
      for (int b = 0; b < 4; b++) wr_reg(8'(4 + b), 8'(k + 1));
    wait_idle();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (log_adr[base + k] !== 32'h1000 + 32'(4 * k) || log_dat[base + k] !== {4{8'(k + 1)}} ||
          log_we[base + k] !== 1'b1) begin
        failures++; $display("FAIL auto_write%0d got=adr %h dat %h exp=adr %h dat %h", k,
                             log_adr[base + k], log_dat[base + k], 32'h1000 + 32'(4 * k), {4{8'(k + 1)}});
      end
    end
    rd_reg(8'h00, q);
    checks++; if (q !== 8'h10) begin failures++; $display("FAIL auto_adr_b0 got=%h exp=10", q); end
    rd_reg(8'h01, q);
    checks++; if (q !== 8'h10) begin failures++; $display("FAIL auto_adr_b1 got=%h exp=10", q); end
    rd_dat = 32'h12345678;
    rd_reg(8'h04, q);
    checks++; if (q !== 8'h04) begin failures++; $display("FAIL prefetch_old got=%h exp=04", q); end
    wait_idle();
    checks++;
    if (log_adr[base + 4] !== 32'h1010 || log_we[base + 4] !== 1'b0) begin
      failures++; $display("FAIL prefetch_bus got=adr %h we %b exp=adr 1010 we 0", log_adr[base + 4], log_we[base + 4]);
    end
    rd_reg(8'h05, q);
    checks++; if (q !== 8'h56) begin failures++; $display("FAIL prefetch_new got=%h exp=56", q); end
    rd_reg(8'h00, q);
    checks++; if (q !== 8'h14) begin failures++; $display("FAIL prefetch_adr got=%h exp=14", q); end
    wr_reg(8'h08, 8'h00);
  endtask

  task automatic test_dw16();
    logic [7:0] q; int base = log_n;
    use16 = 1'b1;
    wr_reg(8'h00, 8'h03);
    rd_dat = 32'h0000A55A;
    wr_reg(8'h08, 8'h01);
    wait_idle();
    checks++;
    if (log_adr[base] !== 32'h0002 || log_sel[base] !== 4'b0011 || log_we[base] !== 1'b0) begin
      failures++; $display("FAIL dw16_bus got=adr %h sel %b we %b exp=adr 0002 sel 0011 we 0",
                           log_adr[base], log_sel[base], log_we[base]);
    end
    rd_reg(8'h04, q);
    checks++; if (q !== 8'h5A) begin failures++; $display("FAIL dw16_dat0 got=%h exp=5a", q); end
    rd_reg(8'h05, q);
    checks++; if (q !== 8'hA5) begin failures++; $display("FAIL dw16_dat1 got=%h exp=a5", q); end
    rd_reg(8'h06, q);
    checks++; if (q !== 8'h00) begin failures++; $display("FAIL dw16_unmapped got=%h exp=00", q); end
    use16 = 1'b0;
  endtask

  task automatic test_timeout();
    logic [7:0] q;
    ack_mode = 1;
    wr_reg(8'h08, 8'h01);
    wait_idle();
    checks++;
    if (drop_cyc - (acc_cyc + 1) !== 17) begin
      failures++; $display("FAIL timeout_len got=%0d exp=17", drop_cyc - (acc_cyc + 1));
    end
    ack_mode = 0;
    rd_reg(8'h09, q);
    checks++; if (q !== 8'h04) begin failures++; $display("FAIL timeout_stat got=%h exp=04", q); end
    rd_reg(8'h09, q);
    checks++; if (q !== 8'h00) begin failures++; $display("FAIL timeout_clear got=%h exp=00", q); end
  endtask

  task automatic test_err();
    logic [7:0] q;
    wr_reg(8'h00, 8'h20);
    ack_mode = 2;
    rd_dat = 32'hCAFEF00D;
    wr_reg(8'h08, 8'h05);
    wait_idle();
    ack_mode = 0;
    rd_reg(8'h04, q);
    checks++; if (q !== 8'h78) begin failures++; $display("FAIL err_dat got=%h exp=78", q); end
    rd_reg(8'h09, q);
    checks++; if (q !== 8'h02) begin failures++; $display("FAIL err_stat got=%h exp=02", q); end
    rd_reg(8'h00, q);
    checks++; if (q !== 8'h20) begin failures++; $display("FAIL err_noinc got=%h exp=20", q); end
    wr_reg(8'h08, 8'h00);
  endtask

  task automatic test_stall_idx();
    logic [7:0] q; int w; int base = log_n;
    stall_cfg = 10;
    wr_reg(8'h08, 8'h02);
    access(1'b1, 1'b1, 8'h33, q, w);
    checks++;
    if (w <= 10 || m_cyc !== 1'b0 || m_req !== 1'b0) begin
      failures++; $display("FAIL idx_held got=wait %0d cyc %b req %b exp=wait>10 cyc 0 req 0", w, m_cyc, m_req);
    end
    stall_cfg = 0;
    access(1'b0, 1'b1, 8'h00, q, w);
    checks++; if (q !== 8'h33) begin failures++; $display("FAIL idx_readback got=%h exp=33", q); end
    checks++;
    if (log_n !== base + 1 || log_we[base] !== 1'b1) begin
      failures++; $display("FAIL stall_write got=n%0d we %b exp=n1 we 1", log_n - base, log_we[base]);
    end
  endtask

  task automatic test_en_hold();
    logic [7:0] q; int w = 0; logic seen = 1'b0;
    en = 1'b0;
    @(negedge clk);
    h_wr = 1'b1; h_asel = 1'b1; h_dsel = 1'b0; h_wdata = 8'h5A;
    @(negedge clk);
    h_wr = 1'b0;
    repeat (3) begin
      if (m_wack) seen = 1'b1;
      @(negedge clk);
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL en_hold got=ack exp=no_ack"); end
    en = 1'b1;
    while (!m_wack && w < 10) begin
      @(negedge clk);
      w++;
    end
    checks++; if (w > 2) begin failures++; $display("FAIL en_resume got=wait %0d exp<=2", w); end
    access(1'b0, 1'b1, 8'h00, q, w);
    checks++; if (q !== 8'h5A) begin failures++; $display("FAIL en_idx got=%h exp=5a", q); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] q; int n = 0;
    ack_mode = 1;
    wr_reg(8'h08, 8'h01);
    while (!(m_cyc && !m_stb) && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n >= 50) begin failures++; $display("FAIL reach_wait got=no_wait exp=wait"); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({m_cyc, m_stb, m_req, a_adr, a_sel, a_wdat} !== '0) begin
      failures++; $display("FAIL async_reset got=cyc %b stb %b req %b adr %h exp=0", m_cyc, m_stb, m_req, a_adr);
    end
    ack_mode = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rd_reg(8'h01, q);
    checks++; if (q !== 8'h00) begin failures++; $display("FAIL reset_lost_adr got=%h exp=00", q); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_auto_inc();
    test_dw16();
    test_timeout();
    test_err();
    test_stall_idx();
    test_en_hold();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adi_wb_bridge.md
# adi_wb_bridge

Parametrised successor to the fixed 32-bit ADI EPP-to-Wishbone path. It sits between the EPP slave register interface (REGS_*) and the Wishbone bus arbiter. Host-visible byte registers stage address and data. A GO write or an auto-trigger byte launches one Wishbone single access with a 4-phase REQ/GNT arbiter handshake, configurable data width, optional address auto-increment and an ACK timeout.

## Interface
- WB_AW, 32: Wishbone address width (8..32).
- WB_DW, 32: Wishbone data width; 8, 16 or 32. NB = WB_DW/8 data byte registers.
- TIMEOUT, 255: cycles waited for ACK/ERR after STB accepted; 0 disables the timeout.
- CLK  in  1  system clock.
- RST_ASYNC  in  1  asynchronous, active-low reset.
- EN  in  1  synchronous enable; when low, the FSM and registers hold state.
- REGS_WRITE_REQ_IN  in  1  byte write request pulse from the EPP slave.
- REGS_READ_REQ_IN  in  1  byte read request pulse.
- REGS_ADDR_SEL_IN  in  1  access targets the index register.
- REGS_DATA_SEL_IN  in  1  access targets the register selected by the index.
- REGS_WRITE_DATA_IN  in  8  write byte.
- REGS_READ_DATA_OUT  out  8  read byte, valid with REGS_READ_ACK_OUT.
- REGS_WRITE_ACK_OUT / REGS_READ_ACK_OUT  out  1 each  single-cycle acks.
- WB_ARB_REQ_OUT  out  1  arbiter request.
- WB_ARB_GNT_IN  in  1  arbiter grant.
- WB_CYC_OUT, WB_STB_OUT, WB_WE_OUT  out  1 each.
- WB_ADR_OUT  out  WB_AW  byte address.
- WB_SEL_OUT  out  WB_DW/8  byte lane selects.
- WB_WR_DAT_OUT  out  WB_DW  write data.
- WB_STALL_IN, WB_ACK_IN, WB_ERR_IN  in  1 each.
- WB_RD_DAT_IN  in  WB_DW  read data.

## Operation
- Index register IDX[7:0] is written via ADDR_SEL. An ADDR_SEL read returns IDX.
- DATA_SEL accesses use this byte map:
  - 0x00-0x03: ADR bytes, little-endian. Bytes at or above WB_AW/8 read 0 and ignore writes.
  - 0x04..0x04+NB-1: DAT bytes. Writes stage write data; reads return the last read data.
  - 0x08: CTRL. bit0 GO_RD, bit1 GO_WR (both self-clearing), bit2 AUTO_INC, bit3 AUTO_TRIG.
  - 0x09: STAT, read-only. bit0 BUSY, bit1 ERR (bus error), bit2 TMO (timeout). Reading STAT clears ERR and TMO.
  - Other indices: read 0x00, writes are acked and ignored.
- Access triggers:
  - Writing CTRL with GO_WR=1 starts a write. GO_RD=1 starts a read. Both set means write wins.
  - With AUTO_TRIG=1, writing the top DAT byte (0x04+NB-1) starts a write.
  - With AUTO_TRIG=1, reading DAT byte 0x04 returns the current data, then starts a read that prefetches the next word.
- FSM states and transitions:
  - IDLE -> REQ on trigger.
  - REQ: WB_ARB_REQ_OUT=1. -> STB on GNT.
  - STB: CYC=STB=1. -> WAIT when STALL=0.
  - WAIT: CYC=1, STB=0. -> REL on ACK, ERR or timeout.
  - REL: REQ=0, CYC=0. -> IDLE when GNT=0.
- Completion in WAIT:
  - On ACK, a read captures WB_RD_DAT_IN into DAT.
  - On ERR, set ERR; the DAT update is skipped.
  - On timeout, set TMO.
- SEL depends on WB_DW:
  - WB_DW=32: all ones; ADR[1:0] forced to 0 on the bus.
  - WB_DW=16: all ones; ADR[0] forced to 0.
  - WB_DW=8: 1'b1.
- Auto-increment: if AUTO_INC=1 and the access ended with ACK, ADR += NB on entering REL, wrapping modulo 2^WB_AW. No increment after ERR or timeout.
- Flow control while BUSY (state ≠ IDLE):
  - DATA_SEL accesses to STAT are acked normally.
  - ADDR_SEL accesses and all other DATA_SEL accesses hold their ack until IDLE, then complete. This stalls EPP through WAIT.
  - Any trigger in a held access is then honoured.
- Only one held request is outstanding at a time. New REQ pulses are not accepted until the held one is acked.

## Timing
- Reset values: all outputs 0; IDX=0, ADR=0, DAT=0, CTRL=0, STAT=0, FSM=IDLE.
- Register ack: one cycle after the REQ pulse when not held. Read data is registered and valid in the ack cycle.
- Trigger to WB_ARB_REQ_OUT: 1 cycle.
- GNT sampled high to CYC/STB: next cycle.
- STB with STALL=0 at a CLK edge drops STB in the next cycle.
- ACK at edge N: CYC=0 and REQ=0 at N+1. BUSY clears one cycle after GNT is seen low.
- Minimum access with GNT registered from REQ and zero-wait ACK: 6 cycles from trigger to IDLE.
- Timeout counter:
  - Starts at 0 on entering WAIT and counts each EN cycle.
  - Reaching TIMEOUT in WAIT ends the access. An ACK in the same cycle wins.
- Reset asserted mid-access drops CYC, STB and REQ immediately (async). Staged registers are lost.
- With EN=0, outputs hold. A REQ pulse arriving while EN=0 is registered and served once EN returns.

## Test plan
- Write ADR=0x0000_1000 and DAT=0xDEADBEEF, then CTRL=0x02 -> one WB cycle with ADR 0x1000, WE=1, SEL=0xF, DAT 0xDEADBEEF; STAT reads 0x00 afterwards.
- AUTO_INC=1, AUTO_TRIG=1, four 4-byte DAT writes -> writes at 0x1000, 0x1004, 0x1008, 0x100C; final ADR reads 0x1010.
- WB_DW=16, read at ADR 0x0003 with the slave returning 0xA55A -> bus ADR 0x0002, SEL=2'b11; DAT bytes read 0x5A, 0xA5.
- Slave never ACKs, TIMEOUT=16 -> CYC drops 17 cycles after STB acceptance; STAT=0x04, then 0x00 on the second read.
- Slave asserts ERR on a read -> DAT unchanged, STAT=0x02, ADR not incremented.
- Slave stalls STB for 10 cycles while the host writes IDX -> the IDX ack is held until IDLE; the host then reads back the written IDX value. Async reset mid-WAIT -> all outputs 0 immediately.
